// File: rtl/draw_pkg.sv
// Shared screen geometry, background colour and drawer FSM state type.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [2:0] BG_COLOUR = 3'b000;
  localparam int CNT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } draw_state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major cx/cy scan counter over a RECT_W x RECT_H rectangle.
module rect_scan_counter
  import draw_pkg::*;
#(
  parameter int RECT_W = 4,
  parameter int RECT_H = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                enable,
  output logic [CNT_BITS-1:0] cx,
  output logic [CNT_BITS-1:0] cy,
  output logic                last
);

  logic cx_last;
  logic cy_last;

  assign cx_last = (cx == CNT_BITS'(RECT_W - 1));
  assign cy_last = (cy == CNT_BITS'(RECT_H - 1));
  assign last    = cx_last && cy_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clear) begin
      cx <= '0;
      cy <= '0;
    end else if (enable) begin
      if (cx_last) begin
        cx <= '0;
        cy <= cy_last ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_drawer.sv
// Rectangle fill engine emitting one VGA pixel write per cycle.
// Build option: define RECT_DRAWER_CLIP_EN to suppress plots that fall off screen.
module rect_drawer
  import draw_pkg::*;
#(
  parameter int RECT_W      = 4,
  parameter int RECT_H      = 4,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOUR_BITS = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [X_BITS-1:0]      x_coords,
  input  logic [Y_BITS-1:0]      y_coords,
  input  logic [COLOUR_BITS-1:0] input_colour,
  input  logic                   erase,
  output logic                   busy,
  output logic                   done,
  output logic [X_BITS-1:0]      finalX,
  output logic [Y_BITS-1:0]      finalY,
  output logic [COLOUR_BITS-1:0] output_colour,
  output logic                   plot
);

  // state | meaning
  // IDLE  | waiting for start (accepted only once busy has dropped)
  // DRAW  | one pixel per cycle, row-major over the rectangle
  // DONE  | single-cycle completion, then back to IDLE

  draw_state_t state, state_nxt;

  logic [X_BITS-1:0]      x0;
  logic [Y_BITS-1:0]      y0;
  logic [COLOUR_BITS-1:0] col;

  logic [CNT_BITS-1:0] cx;
  logic [CNT_BITS-1:0] cy;
  logic                scan_clear;
  logic                scan_en;
  logic                scan_last;
  logic                accept;

  logic [X_BITS-1:0]      px;
  logic [Y_BITS-1:0]      py;
  logic                   in_screen;

  logic                   busy_d;
  logic                   done_d;
  logic                   plot_d;
  logic [X_BITS-1:0]      x_d;
  logic [Y_BITS-1:0]      y_d;
  logic [COLOUR_BITS-1:0] c_d;

  rect_scan_counter #(
    .RECT_W (RECT_W),
    .RECT_H (RECT_H)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (scan_clear),
    .enable (scan_en),
    .cx     (cx),
    .cy     (cy),
    .last   (scan_last)
  );

`ifdef RECT_DRAWER_CLIP_EN
  // One extra bit keeps the sum from wrapping back onto the screen.
  logic [X_BITS:0] sum_x;
  logic [Y_BITS:0] sum_y;

  assign sum_x     = {1'b0, x0} + (X_BITS + 1)'(cx);
  assign sum_y     = {1'b0, y0} + (Y_BITS + 1)'(cy);
  assign px        = sum_x[X_BITS-1:0];
  assign py        = sum_y[Y_BITS-1:0];
  assign in_screen = (sum_x < (X_BITS + 1)'(SCREEN_W)) &&
                     (sum_y < (Y_BITS + 1)'(SCREEN_H));
`else
  assign px        = x0 + X_BITS'(cx);
  assign py        = y0 + Y_BITS'(cy);
  assign in_screen = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    scan_clear = 1'b0;
    scan_en    = 1'b0;
    busy_d     = (state != IDLE);
    done_d     = (state == DONE);
    plot_d     = 1'b0;
    x_d        = finalX;
    y_d        = finalY;
    c_d        = output_colour;
    case (state)
      IDLE: begin
        if (start && !busy) begin
          accept     = 1'b1;
          scan_clear = 1'b1;
          state_nxt  = DRAW;
        end
      end
      DRAW: begin
        scan_en = 1'b1;
        x_d     = px;
        y_d     = py;
        c_d     = col;
        plot_d  = in_screen;
        if (scan_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x0  <= '0;
      y0  <= '0;
      col <= '0;
    end else if (accept) begin
      x0  <= x_coords;
      y0  <= y_coords;
      col <= erase ? COLOUR_BITS'(BG_COLOUR) : input_colour;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      plot          <= 1'b0;
      finalX        <= '0;
      finalY        <= '0;
      output_colour <= '0;
    end else begin
      busy          <= busy_d;
      done          <= done_d;
      plot          <= plot_d;
      finalX        <= x_d;
      finalY        <= y_d;
      output_colour <= c_d;
    end
  end

endmodule

// File: tb/tb_rect_drawer.sv
// Bench for rect_drawer: default 4x4 instance plus an 8x2 instance sharing stimulus.
module tb_rect_drawer;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [7:0] x_coords;
  logic [6:0] y_coords;
  logic [2:0] input_colour;
  logic       erase;

  logic       busy_a  [2];
  logic       done_a  [2];
  logic       plot_a  [2];
  logic [7:0] fx_a    [2];
  logic [6:0] fy_a    [2];
  logic [2:0] col_a   [2];

  int checks;
  int failures;

  rect_drawer u0 (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .x_coords      (x_coords),
    .y_coords      (y_coords),
    .input_colour  (input_colour),
    .erase         (erase),
    .busy          (busy_a[0]),
    .done          (done_a[0]),
    .finalX        (fx_a[0]),
    .finalY        (fy_a[0]),
    .output_colour (col_a[0]),
    .plot          (plot_a[0])
  );

  rect_drawer #(.RECT_W(8), .RECT_H(2)) u1 (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .x_coords      (x_coords),
    .y_coords      (y_coords),
    .input_colour  (input_colour),
    .erase         (erase),
    .busy          (busy_a[1]),
    .done          (done_a[1]),
    .finalX        (fx_a[1]),
    .finalY        (fy_a[1]),
    .output_colour (col_a[1]),
    .plot          (plot_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d exp=%0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: a request is a numbered sequence of cycles after acceptance.
  int  mw [2] = '{4, 8};
  int  mh [2] = '{4, 2};
  bit  act [2];
  int  t   [2];
  int  x0  [2];
  int  y0  [2];
  int  c0  [2];
  int  e_busy [2];
  int  e_done [2];
  int  e_plot [2];
  int  e_x    [2];
  int  e_y    [2];
  int  e_c    [2];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 0; t[i] = 0;
        e_busy[i] = 0; e_done[i] = 0; e_plot[i] = 0;
        e_x[i] = 0; e_y[i] = 0; e_c[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int n;
        n = mw[i] * mh[i];
        if (act[i]) begin
          t[i]++;
          e_plot[i] = 0;
          if (t[i] <= n) begin
            int p, xs, ys;
            p  = t[i] - 1;
            xs = x0[i] + p % mw[i];
            ys = y0[i] + p / mw[i];
            e_x[i] = xs % 256;
            e_y[i] = ys % 128;
            e_c[i] = c0[i];
`ifdef RECT_DRAWER_CLIP_EN
            e_plot[i] = (xs < 160 && ys < 120) ? 1 : 0;
`else
            e_plot[i] = 1;
`endif
          end
          e_busy[i] = (t[i] <= n + 1) ? 1 : 0;
          e_done[i] = (t[i] == n + 1) ? 1 : 0;
          if (t[i] >= n + 2) act[i] = 0;
        end else if (start) begin
          act[i] = 1;
          t[i]   = 0;
          x0[i]  = int'(x_coords);
          y0[i]  = int'(y_coords);
          c0[i]  = erase ? 0 : int'(input_colour);
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("busy", i, int'(busy_a[i]), e_busy[i]);
      chk("done", i, int'(done_a[i]), e_done[i]);
      chk("plot", i, int'(plot_a[i]), e_plot[i]);
      chk("finalX", i, int'(fx_a[i]), e_x[i]);
      chk("finalY", i, int'(fy_a[i]), e_y[i]);
      chk("colour", i, int'(col_a[i]), e_c[i]);
    end
  end

  task automatic drive(input int x, input int y, input int c, input bit e, input bit s);
    x_coords     = 8'(x);
    y_coords     = 7'(y);
    input_colour = 3'(c);
    erase        = e;
    start        = s;
  endtask

  // Issue a request sampled at the next posedge (edge 0); returns after edge 0.
  task automatic req(input int x, input int y, input int c, input bit e);
    @(negedge clk);
    drive(x, y, c, e, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  int n_plot;

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    drive(0, 0, 0, 1'b0, 1'b0);
    #1;
    chk("rst_busy", 0, int'(busy_a[0]), 0);
    chk("rst_plot", 0, int'(plot_a[0]), 0);
    chk("rst_x", 0, int'(fx_a[0]), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Basic draw at (10,85), restart attempt with (0,0) sampled at cycle 5.
    req(10, 85, 4, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #2;
      chk("lit_plot", 0, int'(plot_a[0]), (k <= 16) ? 1 : 0);
      chk("lit_busy", 0, int'(busy_a[0]), (k <= 17) ? 1 : 0);
      chk("lit_done", 0, int'(done_a[0]), (k == 17) ? 1 : 0);
      chk("lit_done", 1, int'(done_a[1]), (k == 17) ? 1 : 0);
      if (k == 1) begin
        chk("lit_x_first", 0, int'(fx_a[0]), 10);
        chk("lit_y_first", 0, int'(fy_a[0]), 85);
        chk("lit_c_first", 0, int'(col_a[0]), 4);
      end
      if (k == 5) chk("lit_x_row1", 0, int'(fx_a[0]), 10);
      if (k == 5) chk("lit_y_row1", 0, int'(fy_a[0]), 86);
      if (k == 8) chk("lit_x_row0_end", 1, int'(fx_a[1]), 17);
      if (k == 9) chk("lit_y_row1", 1, int'(fy_a[1]), 86);
      if (k == 16) begin
        chk("lit_x_last", 0, int'(fx_a[0]), 13);
        chk("lit_y_last", 0, int'(fy_a[0]), 88);
      end
      @(negedge clk);
      if (k == 4) drive(0, 0, 7, 1'b0, 1'b1);
      else start = 1'b0;
    end
    repeat (3) @(posedge clk);

    // Erase fill.
    req(40, 20, 7, 1'b1);
    @(posedge clk);
    #2;
    chk("lit_erase_c", 0, int'(col_a[0]), 0);
    chk("lit_erase_plot", 0, int'(plot_a[0]), 1);
    repeat (20) @(posedge clk);

    // Screen edge at (158,118).
    n_plot = 0;
    req(158, 118, 2, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #2;
      n_plot += int'(plot_a[0]);
      chk("edge_done", 0, int'(done_a[0]), (k == 17) ? 1 : 0);
      if (k == 16) begin
        chk("edge_x_last", 0, int'(fx_a[0]), 161);
        chk("edge_y_last", 0, int'(fy_a[0]), 121);
      end
    end
`ifdef RECT_DRAWER_CLIP_EN
    chk("edge_plots", 0, n_plot, 4);
`else
    chk("edge_plots", 0, n_plot, 16);
`endif
    repeat (3) @(posedge clk);

    // Reset mid-draw at cycle 7.
    req(20, 30, 5, 1'b0);
    repeat (7) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("abort_plot", 0, int'(plot_a[0]), 0);
    chk("abort_busy", 0, int'(busy_a[0]), 0);
    chk("abort_done", 0, int'(done_a[0]), 0);
    chk("abort_x", 0, int'(fx_a[0]), 0);
    chk("abort_y", 0, int'(fy_a[0]), 0);
    @(negedge clk);
    resetn = 1'b1;
    req(50, 60, 6, 1'b0);
    repeat (20) @(posedge clk);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        resetn = 1'b0;
      end else begin
        resetn = 1'b1;
      end
      drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    resetn = 1'b1;
    start  = 1'b0;
    repeat (25) @(posedge clk);
    #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
